// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage: load funct3 codes,
// the load-queue entry layout and the load alignment/extension function.
package wb_pkg;

  localparam int WB_XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] off;
  } ldq_entry_t;

  // Select the byte/half addressed by off and extend it; unknown f3 keeps the word.
  function automatic logic [WB_XLEN-1:0] extend_load(input logic [2:0] f3,
                                                     input logic [1:0] off,
                                                     input logic [WB_XLEN-1:0] word);
    logic [7:0]         byte_v;
    logic [15:0]        half_v;
    logic [WB_XLEN-1:0] res_v;
    byte_v = word[{off, 3'b000} +: 8];
    half_v = word[{off[1], 4'b0000} +: 16];
    case (f3)
      F3_LB:   res_v = {{(WB_XLEN-8){byte_v[7]}}, byte_v};
      F3_LH:   res_v = {{(WB_XLEN-16){half_v[15]}}, half_v};
      F3_LW:   res_v = word;
      F3_LBU:  res_v = {{(WB_XLEN-8){1'b0}}, byte_v};
      F3_LHU:  res_v = {{(WB_XLEN-16){1'b0}}, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

endpackage

// File: rtl/wb_ldq.sv
// In-order queue of outstanding loads. Pointers wrap naturally (DEPTH is a
// power of two); a separate occupancy count tells full from empty.
module wb_ldq
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  ldq_entry_t din,
  output ldq_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);

  ldq_entry_t      mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW:0]     count_r;
  logic            do_push_s;
  logic            do_pop_s;

  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign full      = (count_r == (PW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign head      = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: sole driver of the regfile write port. Load responses
// always win over ALU results; a per-register pending-load count drives the
// busy scoreboard used for decode stalls. Optional feature macro:
// WB_BYPASS_EN adds fwd1_hit/fwd2_hit/fwd_data forwarding outputs.
module wb_stage
  import wb_pkg::*;
#(
  parameter int LDQ_DEPTH = 4,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue_valid,
  output logic            ld_issue_ready,
  input  logic [4:0]      ld_issue_rd,
  input  logic [2:0]      ld_issue_f3,
  input  logic [1:0]      ld_issue_off,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wr_req,
  output logic [XLEN-1:0] wr_data,
  output logic [4:0]      rd,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  output logic            dec_stall,
  output logic [31:0]     busy,
  output logic            ldq_err
`ifdef WB_BYPASS_EN
  ,
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd_data
`endif
);

  // Counter wide enough that every queue slot may target the same register.
  localparam int CNT_W = $clog2(LDQ_DEPTH + 1);

  ldq_entry_t       head_s;
  ldq_entry_t       push_entry_s;
  logic             full_s;
  logic             empty_s;
  logic             pop_s;
  logic             push_s;
  logic             alu_fire_s;
  logic [31:0]      busy_s;
  logic [31:0]      inc_s;
  logic [31:0]      dec_s;
  logic [CNT_W-1:0] pend_cnt_r [32];

  assign push_entry_s = '{rd: ld_issue_rd, f3: ld_issue_f3, off: ld_issue_off};

  wb_ldq #(.DEPTH(LDQ_DEPTH)) u_ldq (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .head  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Scoreboard view: a register is busy while its pending count is non-zero.
  always_comb begin
    busy_s = '0;
    for (int i = 1; i < 32; i++) begin
      busy_s[i] = (pend_cnt_r[i] != '0);
    end
  end

  assign busy = busy_s;

  // Arbitration: load responses pre-empt ALU; ALU also waits on a pending load to its rd.
  always_comb begin
    alu_ready      = 1'b0;
    alu_fire_s     = 1'b0;
    pop_s          = 1'b0;
    ld_issue_ready = 1'b0;
    push_s         = 1'b0;
    dec_stall      = 1'b0;
    alu_ready      = !mem_rvalid && !((alu_rd != 5'd0) && busy_s[alu_rd]);
    alu_fire_s     = alu_valid && alu_ready;
    pop_s          = mem_rvalid && !empty_s;
    ld_issue_ready = !full_s || mem_rvalid;
    push_s         = ld_issue_valid && ld_issue_ready;
    dec_stall      = ((dec_rs1 != 5'd0) && busy_s[dec_rs1]) ||
                     ((dec_rs2 != 5'd0) && busy_s[dec_rs2]);
  end

  // One-hot increment/decrement requests per register; x0 is never tracked.
  always_comb begin
    inc_s = '0;
    dec_s = '0;
    inc_s = (push_s ? (32'd1 << ld_issue_rd) : 32'd0) & 32'hFFFF_FFFE;
    dec_s = (pop_s  ? (32'd1 << head_s.rd)   : 32'd0) & 32'hFFFF_FFFE;
  end

  // Pending-load counters; an issue and a return to the same rd cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        pend_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (inc_s[i] && !dec_s[i]) begin
          pend_cnt_r[i] <= pend_cnt_r[i] + 1'b1;
        end else if (dec_s[i] && !inc_s[i]) begin
          pend_cnt_r[i] <= pend_cnt_r[i] - 1'b1;
        end
      end
    end
  end

  // Registered regfile write port and sticky response-without-load error.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_req  <= 1'b0;
      wr_data <= '0;
      rd      <= 5'd0;
      ldq_err <= 1'b0;
    end else begin
      if (mem_rvalid && empty_s) begin
        ldq_err <= 1'b1;
      end
      if (pop_s) begin
        if (head_s.rd != 5'd0) begin
          wr_req  <= 1'b1;
          rd      <= head_s.rd;
          wr_data <= XLEN'(extend_load(head_s.f3, head_s.off, WB_XLEN'(mem_rdata)));
        end else begin
          wr_req  <= 1'b0;
        end
      end else if (alu_fire_s && (alu_rd != 5'd0)) begin
        wr_req  <= 1'b1;
        rd      <= alu_rd;
        wr_data <= alu_data;
      end else begin
        wr_req  <= 1'b0;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd1_hit = wr_req && (rd != 5'd0) && (rd == dec_rs1);
  assign fwd2_hit = wr_req && (rd != 5'd0) && (rd == dec_rs2);
  assign fwd_data = wr_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, all checked against a queue-based behavioural model.
module tb_wb_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue_valid, ld_issue_ready;
  logic [4:0]  ld_issue_rd;
  logic [2:0]  ld_issue_f3;
  logic [1:0]  ld_issue_off;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wr_req;
  logic [31:0] wr_data;
  logic [4:0]  rd, dec_rs1, dec_rs2;
  logic        dec_stall;
  logic [31:0] busy;
  logic        ldq_err;
`ifdef WB_BYPASS_EN
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd_data;
`endif

  always #5 clk = ~clk;

  wb_stage #(.LDQ_DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready),
    .ld_issue_rd(ld_issue_rd), .ld_issue_f3(ld_issue_f3), .ld_issue_off(ld_issue_off),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wr_req(wr_req), .wr_data(wr_data), .rd(rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_stall(dec_stall),
    .busy(busy), .ldq_err(ldq_err)
`ifdef WB_BYPASS_EN
    , .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data)
`endif
  );

  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] off;
  } ent_t;

  ent_t        q[$];
  logic        m_wr_req = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_wr_data = 32'd0;
  logic        m_err = 1'b0;
  int          n_total = 0;
  int          n_pass  = 0;

  function automatic logic m_busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    v = 32'd0;
    for (int r = 1; r < 32; r++) v[r] = m_busy(5'(r));
    return v;
  endfunction

  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256     : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'h1_0000  : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_issue_valid = 1'b0; ld_issue_rd = 5'd0; ld_issue_f3 = 3'd0; ld_issue_off = 2'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0; dec_rs1 = 5'd0; dec_rs2 = 5'd0;
  endtask

  task automatic issue(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] off);
    ld_issue_valid = 1'b1; ld_issue_rd = r; ld_issue_f3 = f3; ld_issue_off = off;
  endtask

  // One clock: check combinational outputs, advance model at the edge, check registers.
  task automatic step();
    logic m_ready, m_ldr;
    ent_t e;
    #2;
    m_ready = !mem_rvalid && !((alu_rd != 5'd0) && m_busy(alu_rd));
    m_ldr   = (q.size() < DEPTH) || mem_rvalid;
    check("alu_ready", 32'(alu_ready), 32'(m_ready));
    check("ld_issue_ready", 32'(ld_issue_ready), 32'(m_ldr));
    check("dec_stall", 32'(dec_stall), 32'(m_busy(dec_rs1) || m_busy(dec_rs2)));
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_wr_req = 1'b0; m_rd = 5'd0; m_wr_data = 32'd0; m_err = 1'b0;
    end else begin
      if (mem_rvalid && q.size() == 0) m_err = 1'b1;
      if (mem_rvalid && q.size() > 0) begin
        e = q.pop_front();
        if (e.rd != 5'd0) begin
          m_wr_req = 1'b1; m_rd = e.rd; m_wr_data = ref_ext(e.f3, e.off, mem_rdata);
        end else begin
          m_wr_req = 1'b0;
        end
      end else if (alu_valid && m_ready && alu_rd != 5'd0) begin
        m_wr_req = 1'b1; m_rd = alu_rd; m_wr_data = alu_data;
      end else begin
        m_wr_req = 1'b0;
      end
      if (ld_issue_valid && m_ldr) q.push_back('{rd: ld_issue_rd, f3: ld_issue_f3, off: ld_issue_off});
    end
    #1;
    check("wr_req", 32'(wr_req), 32'(m_wr_req));
    check("rd", 32'(rd), 32'(m_rd));
    check("wr_data", wr_data, m_wr_data);
    check("busy", busy, m_busy_vec());
    check("ldq_err", 32'(ldq_err), 32'(m_err));
`ifdef WB_BYPASS_EN
    check("fwd1_hit", 32'(fwd1_hit), 32'(m_wr_req && m_rd != 5'd0 && m_rd == dec_rs1));
    check("fwd2_hit", 32'(fwd2_hit), 32'(m_wr_req && m_rd != 5'd0 && m_rd == dec_rs2));
    check("fwd_data", fwd_data, m_wr_data);
`endif
  endtask

  initial begin
    logic [2:0] f3_tab [6];
    f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2;
    f3_tab[3] = 3'd4; f3_tab[4] = 3'd5; f3_tab[5] = 3'd3;

    // Reset
    idle(); reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    step();
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_busy", busy, 32'd0);
    reset = 1'b0;

    // 1: ALU write, one-cycle latency
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    step();
    check("t1_wr_req", 32'(wr_req), 32'd1);
    check("t1_rd", 32'(rd), 32'd5);
    check("t1_wr_data", wr_data, 32'h1234);

    // 2: LB off=2 sign-extends 0x80
    idle(); issue(5'd3, 3'd0, 2'd2);
    step();
    idle();
    check("t2_busy_set", 32'(busy[3]), 32'd1);
    step();
    check("t2_busy_hold", 32'(busy[3]), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h0080_0000;
    step();
    check("t2_wr_data", wr_data, 32'hFFFF_FF80);
    check("t2_busy_clr", 32'(busy[3]), 32'd0);

    // 3: load response pre-empts ALU, ALU written next cycle
    idle(); issue(5'd9, 3'd2, 2'd0);
    step();
    idle();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h55;
    #2 check("t3_alu_blocked", 32'(alu_ready), 32'd0);
    step();
    check("t3_ld_rd", 32'(rd), 32'd9);
    check("t3_ld_data", wr_data, 32'hCAFE_F00D);
    mem_rvalid = 1'b0;
    step();
    check("t3_alu_rd", 32'(rd), 32'd6);
    check("t3_alu_data", wr_data, 32'h55);

    // 4: fill the queue, then pop and push in the same cycle
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      issue(5'(10 + i), 3'd5, 2'(i));
      step();
    end
    idle();
    #2 check("t4_full", 32'(ld_issue_ready), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h8765_4321; issue(5'd20, 3'd1, 2'd3);
    #1 check("t4_ready_on_pop", 32'(ld_issue_ready), 32'd1);
    step();
    check("t4_busy20", 32'(busy[20]), 32'd1);
    check("t4_busy10", 32'(busy[10]), 32'd0);
    idle();
    #2 check("t4_still_full", 32'(ld_issue_ready), 32'd0);
    step();
    for (int i = 0; i < DEPTH; i++) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom;
      step();
    end

    // 5: two loads to x7 keep it busy until the second returns
    idle(); issue(5'd7, 3'd2, 2'd0);
    step();
    issue(5'd7, 3'd1, 2'd2);
    step();
    idle(); dec_rs1 = 5'd7;
    #2 check("t5_stall_2", 32'(dec_stall), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    mem_rvalid = 1'b0;
    #2 check("t5_stall_1", 32'(dec_stall), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'hF00F_0000;
    step();
    check("t5_lh_data", wr_data, 32'hFFFF_F00F);
    mem_rvalid = 1'b0;
    #2 check("t5_stall_0", 32'(dec_stall), 32'd0);
    step();

    // 6: x0 never written, orphan response, reset mid-load
    idle(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    step();
    check("t6_x0_no_wr", 32'(wr_req), 32'd0);
    idle(); mem_rvalid = 1'b1; mem_rdata = 32'h1;
    step();
    check("t6_ldq_err", 32'(ldq_err), 32'd1);
    check("t6_no_wr", 32'(wr_req), 32'd0);
    idle(); issue(5'd12, 3'd0, 2'd1);
    step();
    idle(); reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_busy", busy, 32'd0);
    check("t6_rst_err", 32'(ldq_err), 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      alu_valid      = ($urandom_range(1, 0) == 1);
      alu_rd         = 5'($urandom_range(31, 0));
      alu_data       = $urandom;
      ld_issue_valid = ($urandom_range(9, 0) < 4);
      ld_issue_rd    = 5'($urandom_range(31, 0));
      ld_issue_f3    = f3_tab[$urandom_range(5, 0)];
      ld_issue_off   = 2'($urandom_range(3, 0));
      mem_rvalid     = (q.size() > 0) ? ($urandom_range(2, 0) == 0)
                                      : ($urandom_range(99, 0) == 0);
      mem_rdata      = $urandom;
      dec_rs1        = 5'($urandom_range(31, 0));
      dec_rs2        = 5'($urandom_range(31, 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
